// File: rtl/hazard_unit.sv
// hazard_unit: load-use, memory-freeze and redirect control for the 5-stage RV32I pipeline.
// Optional HAZARD_PERF_CNT_EN adds saturating stall/flush counters. Rev 1.0
`default_nettype none

module hazard_unit #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [RW-1:0] id_sr1,
  input  logic [RW-1:0] id_sr2,
  input  logic          id_use1,
  input  logic          id_use2,
  input  logic [RW-1:0] ex_dr,
  input  logic          ex_load,
  input  logic          br_taken,
  input  logic          imem_read,
  input  logic          imem_resp,
  input  logic [DW-1:0] imem_rdata,
  input  logic          dmem_req,
  input  logic          dmem_resp,
  output logic          stall_if,
  output logic          stall_id,
  output logic          stall_ex,
  output logic          stall_mem,
  output logic          stall_wb,
  output logic          bubble_ex,
  output logic          flush_id,
  output logic          imem_req_en,
  output logic          dmem_req_en,
  output logic [DW-1:0] if_inst,
  output logic          if_inst_sel
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]   lu_stall_cnt,
  output logic [31:0]   mem_stall_cnt,
  output logic [31:0]   flush_cnt
`endif
);

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic          i_done;
  logic          d_done;
  logic [DW-1:0] ibuf;

  logic i_busy;
  logic d_busy;
  logic freeze;
  logic load_use;
  logic track;
  logic lu_stall;

  assign load_use = ex_load & (ex_dr != '0) &
                    ((id_use1 & (ex_dr == id_sr1)) | (id_use2 & (ex_dr == id_sr2)));

  assign i_busy = imem_read & ~imem_resp & ~i_done;
  assign d_busy = dmem_req  & ~dmem_resp & ~d_done;
  assign freeze = i_busy | d_busy;

  // Responses are remembered while frozen and on the release cycle itself.
  assign track = freeze | (state == MEM_WAIT);

  always_comb begin
    state_nxt   = state;
    stall_if    = 1'b0;
    stall_id    = 1'b0;
    stall_ex    = 1'b0;
    stall_mem   = 1'b0;
    stall_wb    = 1'b0;
    bubble_ex   = 1'b0;
    flush_id    = 1'b0;
    lu_stall    = 1'b0;
    imem_req_en = 1'b1;
    dmem_req_en = 1'b1;
    if_inst_sel = i_done;
    if_inst     = i_done ? ibuf : imem_rdata;

    case (state)
      RUN:      if (freeze)  state_nxt = MEM_WAIT;
      MEM_WAIT: if (!freeze) state_nxt = RUN;
      default:  state_nxt = RUN;
    endcase

    // Outputs fall to reset values as soon as rst rises, not at the next edge.
    if (!rst) begin
      imem_req_en = ~i_done;
      dmem_req_en = ~d_done;
      if (freeze) begin
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        stall_ex  = 1'b1;
        stall_mem = 1'b1;
        stall_wb  = 1'b1;
      end else if (br_taken) begin
        flush_id  = 1'b1;
        bubble_ex = 1'b1;
      end else if (load_use) begin
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        bubble_ex = 1'b1;
        lu_stall  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // A response set takes precedence over the clear, so a flag set on the
  // release cycle is visible for one cycle before it drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_done <= 1'b0;
      d_done <= 1'b0;
      ibuf   <= '0;
    end else begin
      if (track && imem_resp) begin
        i_done <= 1'b1;
        ibuf   <= imem_rdata;
      end else if (!stall_if) begin
        i_done <= 1'b0;
      end
      if (track && dmem_resp) begin
        d_done <= 1'b1;
      end else if (!stall_if) begin
        d_done <= 1'b0;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lu_stall_cnt  <= '0;
      mem_stall_cnt <= '0;
      flush_cnt     <= '0;
    end else begin
      if (lu_stall  && (lu_stall_cnt  != '1)) lu_stall_cnt  <= lu_stall_cnt  + 32'd1;
      if (stall_mem && (mem_stall_cnt != '1)) mem_stall_cnt <= mem_stall_cnt + 32'd1;
      if (flush_id  && (flush_cnt     != '1)) flush_cnt     <= flush_cnt     + 32'd1;
    end
  end
`else
  logic unused_lu;
  assign unused_lu = lu_stall;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit.
`default_nettype none

module tb_hazard_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_sr1, id_sr2, ex_dr;
  logic        id_use1, id_use2, ex_load, br_taken;
  logic        imem_read, imem_resp, dmem_req, dmem_resp;
  logic [31:0] imem_rdata;
  logic        stall_if, stall_id, stall_ex, stall_mem, stall_wb;
  logic        bubble_ex, flush_id, imem_req_en, dmem_req_en, if_inst_sel;
  logic [31:0] if_inst;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] lu_stall_cnt, mem_stall_cnt, flush_cnt;
`endif

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  hazard_unit #(.DW(32), .RW(5)) dut (
    .clk(clk), .rst(rst),
    .id_sr1(id_sr1), .id_sr2(id_sr2), .id_use1(id_use1), .id_use2(id_use2),
    .ex_dr(ex_dr), .ex_load(ex_load), .br_taken(br_taken),
    .imem_read(imem_read), .imem_resp(imem_resp), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_resp(dmem_resp),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex),
    .stall_mem(stall_mem), .stall_wb(stall_wb),
    .bubble_ex(bubble_ex), .flush_id(flush_id),
    .imem_req_en(imem_req_en), .dmem_req_en(dmem_req_en),
    .if_inst(if_inst), .if_inst_sel(if_inst_sel)
`ifdef HAZARD_PERF_CNT_EN
    , .lu_stall_cnt(lu_stall_cnt), .mem_stall_cnt(mem_stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  // {stall_if,stall_id,stall_ex,stall_mem,stall_wb,bubble_ex,flush_id,imem_req_en,dmem_req_en,if_inst_sel}
  logic [9:0] ctl;
  assign ctl = {stall_if, stall_id, stall_ex, stall_mem, stall_wb,
                bubble_ex, flush_id, imem_req_en, dmem_req_en, if_inst_sel};

  localparam logic [9:0] IDLE   = 10'b0000000110;
  localparam logic [9:0] FREEZE = 10'b1111100110;
  localparam logic [9:0] LU     = 10'b1100010110;
  localparam logic [9:0] REDIR  = 10'b0000011110;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h required %h", tag, obs, exp);
  endtask

  task automatic clear_inputs();
    id_sr1 = '0; id_sr2 = '0; ex_dr = '0;
    id_use1 = 0; id_use2 = 0; ex_load = 0; br_taken = 0;
    imem_read = 0; imem_resp = 0; dmem_req = 0; dmem_resp = 0;
    imem_rdata = '0;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    #2;
    chk("reset_ctl", 32'(ctl), 32'(IDLE));
`ifdef HAZARD_PERF_CNT_EN
    chk("reset_cnt", lu_stall_cnt | mem_stall_cnt | flush_cnt, 32'd0);
`endif
    @(negedge clk); rst = 1'b0;

    // Load-use via sr2: one stall cycle, then the bubble sits in EX.
    ex_load = 1; ex_dr = 5; id_sr2 = 5; id_use2 = 1;
    #1 chk("lu_sr2", 32'(ctl), 32'(LU));
    @(negedge clk); ex_load = 0;
    #1 chk("lu_after", 32'(ctl), 32'(IDLE));

    @(negedge clk); clear_inputs(); ex_load = 1; ex_dr = 7; id_sr1 = 7; id_use1 = 1;
    #1 chk("lu_sr1", 32'(ctl), 32'(LU));

    @(negedge clk); id_use1 = 0; id_sr2 = 7;
    #1 chk("lu_no_use", 32'(ctl), 32'(IDLE));

    @(negedge clk); clear_inputs(); ex_load = 1; ex_dr = 0; id_sr1 = 0; id_use1 = 1;
    #1 chk("lu_x0", 32'(ctl), 32'(IDLE));

    @(negedge clk); clear_inputs(); ex_load = 1; ex_dr = 5; id_sr1 = 5; id_use1 = 1; br_taken = 1;
    #1 chk("br_over_lu", 32'(ctl), 32'(REDIR));

    // Data freeze: resp lands in cycle 5.
    @(negedge clk); clear_inputs(); dmem_req = 1;
    for (int c = 0; c < 5; c++) begin
      #1 chk($sformatf("dfrz_c%0d", c), 32'(ctl), 32'(FREEZE));
      @(negedge clk);
    end
    dmem_resp = 1;
    #1 chk("dfrz_rel", 32'(ctl), 32'(IDLE));
    @(negedge clk); clear_inputs();
    #1 chk("dfrz_done", 32'(ctl), 32'b0000000100);
    @(negedge clk);
    #1 chk("dfrz_clr", 32'(ctl), 32'(IDLE));

    // Instruction returns mid-freeze and is replayed from the buffer.
    @(negedge clk); imem_read = 1; dmem_req = 1;
    #1 chk("ifrz_c0", 32'(ctl), 32'(FREEZE));
    @(negedge clk); imem_resp = 1; imem_rdata = 32'h00A00093;
    #1 chk("ifrz_c1", 32'(ctl), 32'(FREEZE));
    @(negedge clk); imem_resp = 0; imem_rdata = 32'hDEADBEEF;
    #1 chk("ifrz_c2", 32'(ctl), 32'b1111100011);
    chk("ifrz_c2_inst", if_inst, 32'h00A00093);
    @(negedge clk); dmem_resp = 1;
    #1 chk("ifrz_c3", 32'(ctl), 32'b0000000011);
    chk("ifrz_c3_inst", if_inst, 32'h00A00093);
    @(negedge clk); imem_read = 0; dmem_req = 0; dmem_resp = 0;
    #1 chk("ifrz_c4", 32'(ctl), 32'b0000000100);
    chk("ifrz_c4_inst", if_inst, 32'hDEADBEEF);
    @(negedge clk);
    #1 chk("ifrz_c5", 32'(ctl), 32'(IDLE));

    // Both responses in the same cycle.
    @(negedge clk); clear_inputs(); imem_read = 1; dmem_req = 1;
    #1 chk("both_c0", 32'(ctl), 32'(FREEZE));
    @(negedge clk); imem_resp = 1; dmem_resp = 1; imem_rdata = 32'h12345678;
    #1 chk("both_rel", 32'(ctl), 32'(IDLE));
    @(negedge clk); clear_inputs();
    #1 chk("both_flags", 32'(ctl), 32'b0000000001);
    chk("both_inst", if_inst, 32'h12345678);
    @(negedge clk);
    #1 chk("both_clr", 32'(ctl), 32'(IDLE));

    // Taken branch in the release cycle.
    @(negedge clk); imem_read = 1;
    #1 chk("brrel_c0", 32'(ctl), 32'(FREEZE));
    @(negedge clk); imem_resp = 1; br_taken = 1; imem_rdata = 32'h0000006F;
    #1 chk("brrel_rel", 32'(ctl), 32'(REDIR));
    @(negedge clk); clear_inputs();
    #1 chk("brrel_c2", 32'(ctl), 32'b0000000011);
    @(negedge clk);
    #1 chk("brrel_c3", 32'(ctl), 32'(IDLE));

    // Reset during a freeze after the buffer has been loaded.
    @(negedge clk); imem_read = 1; dmem_req = 1;
    @(negedge clk); imem_resp = 1; imem_rdata = 32'hCAFEF00D;
    @(negedge clk); imem_resp = 0; imem_rdata = 32'h00000013;
    #1 chk("rst_pre", 32'(ctl), 32'b1111100011);
    #1 rst = 1'b1;
    #1 chk("rst_ctl", 32'(ctl), 32'(IDLE));
    chk("rst_inst", if_inst, 32'h00000013);
`ifdef HAZARD_PERF_CNT_EN
    chk("rst_cnt", lu_stall_cnt | mem_stall_cnt | flush_cnt, 32'd0);
`endif
    @(negedge clk); clear_inputs(); imem_rdata = 32'h00000033; rst = 1'b0;
    #1 chk("rst_after", 32'(ctl), 32'(IDLE));
    chk("rst_after_inst", if_inst, 32'h00000033);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
